// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
//   Constants shared by the stopwatch control unit and the datapath:
//   FSM state encodings (also shown on the debug LEDs), the default debounce
//   sample period, and the tick-generator terminal count.
//   No ports (package).
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    // FSM state encodings; code 2'd3 is illegal and recovers to ST_STOP.
    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    // 1 kHz debounce sampling from a 100 MHz clock.
    localparam int unsigned DB_TICK_DEFAULT  = 32'd100_000;
    localparam int unsigned DB_DEPTH_DEFAULT = 32'd4;

    // Tick generator terminal count: 100 MHz / 100 Hz (hundredths of a second).
    localparam int unsigned F_COUNT = 32'd1_000_000;

    // Counter width for a 0..n-1 counter, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   One push-button input path: 2-flop synchroniser, DB_DEPTH-deep sample
//   shift register clocked by a shared sample strobe, hysteretic debounced
//   level, and a 1-cycle press pulse on the debounced rising edge only.
// Ports
//   clk    in  1  system clock
//   rst    in  1  asynchronous active-high reset
//   sample in  1  1-cycle sample strobe shared by all buttons
//   btn    in  1  raw asynchronous button, active-high
//   press  out 1  1-cycle pulse on debounced 0->1 edge (registered)
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int unsigned DB_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sample,
    input  logic btn,
    output logic press
);

    logic                sync1_r;
    logic                sync2_r;
    logic [DB_DEPTH-1:0] shift_r;
    logic                level_r;
    logic                level_next_s;
    logic                press_r;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

    // Sample history, advanced only on the shared strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r <= {DB_DEPTH{1'b0}};
        end else if (sample) begin
            shift_r <= {shift_r[DB_DEPTH-2:0], sync2_r};
        end else begin
            shift_r <= shift_r;
        end
    end

    // Level changes only when the whole history agrees; mixed history holds.
    always_comb begin
        level_next_s = level_r;
        if (&shift_r) begin
            level_next_s = 1'b1;
        end else if (~|shift_r) begin
            level_next_s = 1'b0;
        end else begin
            level_next_s = level_r;
        end
    end

    // Debounced level and its rising-edge pulse; releases produce nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_r <= 1'b0;
            press_r <= 1'b0;
        end else begin
            level_r <= level_next_s;
            press_r <= level_next_s & ~level_r;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/stopwatch_cu.sv
// -----------------------------------------------------------------------------
// stopwatch_cu
//   Stopwatch control unit. Debounces the run/stop, clear and lap buttons
//   and runs a Moore FSM (STOP/RUN/CLEAR) that drives the datapath run and
//   clear controls plus the lap-freeze flag for the display mux.
// Ports
//   clk            in  1  system clock, 100 MHz
//   rst            in  1  asynchronous active-high reset
//   i_btn_runstop  in  1  raw run/stop button
//   i_btn_clear    in  1  raw clear button
//   i_btn_lap      in  1  raw lap button
//   o_runstop      out 1  1 = datapath counting (state RUN)
//   o_clear        out 1  1-cycle datapath clear (state CLEAR)
//   o_lap_freeze   out 1  1 = display shows frozen lap value
//   o_state        out 2  current FSM state for debug LEDs
// -----------------------------------------------------------------------------
module stopwatch_cu
    import stopwatch_pkg::*;
#(
    parameter int unsigned DB_TICK  = DB_TICK_DEFAULT,
    parameter int unsigned DB_DEPTH = DB_DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_runstop,
    input  logic       i_btn_clear,
    input  logic       i_btn_lap,
    output logic       o_runstop,
    output logic       o_clear,
    output logic       o_lap_freeze,
    output logic [1:0] o_state
);

    localparam int unsigned      CNT_W    = cnt_width(DB_TICK);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_TICK - 32'd1);

    logic [CNT_W-1:0] cnt_r;
    logic             sample_s;
    logic             rs_press_s;
    logic             clr_press_s;
    logic             lap_press_s;
    logic [1:0]       state_r;
    logic [1:0]       state_next_s;
    logic             freeze_r;
    logic             freeze_next_s;
    logic             runstop_r;
    logic             clear_r;

    assign sample_s = (cnt_r == CNT_LAST);

    // Free-running sample counter shared by all three buttons; wraps, never saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (sample_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    btn_debounce #(.DB_DEPTH(DB_DEPTH)) u_db_runstop (
        .clk    (clk),
        .rst    (rst),
        .sample (sample_s),
        .btn    (i_btn_runstop),
        .press  (rs_press_s)
    );

    btn_debounce #(.DB_DEPTH(DB_DEPTH)) u_db_clear (
        .clk    (clk),
        .rst    (rst),
        .sample (sample_s),
        .btn    (i_btn_clear),
        .press  (clr_press_s)
    );

    btn_debounce #(.DB_DEPTH(DB_DEPTH)) u_db_lap (
        .clk    (clk),
        .rst    (rst),
        .sample (sample_s),
        .btn    (i_btn_lap),
        .press  (lap_press_s)
    );

    // Next state and lap-freeze flag from the press pulses.
    always_comb begin
        state_next_s  = state_r;
        freeze_next_s = freeze_r;
        case (state_r)
            ST_STOP: begin
                // In STOP, lap can only release a freeze, never set one.
                if (lap_press_s && freeze_r) begin
                    freeze_next_s = 1'b0;
                end else begin
                    freeze_next_s = freeze_r;
                end
                // Clear has priority over a simultaneous run/stop.
                if (clr_press_s) begin
                    state_next_s  = ST_CLEAR;
                    freeze_next_s = 1'b0;
                end else if (rs_press_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            ST_RUN: begin
                if (rs_press_s) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_RUN;
                end
                if (lap_press_s) begin
                    freeze_next_s = ~freeze_r;
                end else begin
                    freeze_next_s = freeze_r;
                end
            end
            ST_CLEAR: begin
                state_next_s  = ST_STOP;
                freeze_next_s = 1'b0;
            end
            default: begin
                state_next_s  = ST_STOP;
                freeze_next_s = 1'b0;
            end
        endcase
    end

    // State, freeze flag and Moore outputs; outputs decode the next state so
    // they change in the same cycle as the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_STOP;
            freeze_r  <= 1'b0;
            runstop_r <= 1'b0;
            clear_r   <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            freeze_r  <= freeze_next_s;
            runstop_r <= (state_next_s == ST_RUN);
            clear_r   <= (state_next_s == ST_CLEAR);
        end
    end

    assign o_runstop    = runstop_r;
    assign o_clear      = clear_r;
    assign o_lap_freeze = freeze_r;
    assign o_state      = state_r;

endmodule
